// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a combinational program memory one word per cycle.
// Optional halt-on-opcode-zero detection is built when INSTR_FETCH_HALT_DETECT_EN is defined.
module instr_fetch #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Enable,
  input  logic              Stall,
  input  logic              Branch_En,
  input  logic [ADDR_W-1:0] Branch_Addr,
  output logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Data,
  output logic [DATA_W-1:0] Instr,
  output logic              Instr_Valid,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted,
  output logic [1:0]        State_Dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RST_PC  = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef INSTR_FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   instr;
  logic                instr_valid;
  logic                halt_hit;

  assign halt_hit = HALT_EN && (Data[DATA_W-1 -: 5] == 5'b00000);

  // Priority inside FETCH: Enable low, then branch (beats stall), then stall, then capture.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      pc          <= RST_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          instr_valid <= 1'b0;
          if (Enable) state <= FETCH;
        end
        FETCH: begin
          if (!Enable) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end else if (Branch_En) begin
            pc          <= Branch_Addr;
            instr_valid <= 1'b0;
          end else if (!Stall) begin
            instr       <= Data;
            instr_valid <= 1'b1;
            // A halt instruction leaves PC pointing at itself.
            if (halt_hit) state <= HALT;
            else          pc    <= pc + PC_ONE;
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Addr        = pc;
  assign PC          = pc;
  assign Instr       = instr;
  assign Instr_Valid = instr_valid;
  assign State_Dbg   = state;

`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign Halted = (state == HALT);
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: run, stall, branch priority, wrap, halt, async reset.
module tb_instr_fetch;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic              Clk;
  logic              Rst_n;
  logic              Enable;
  logic              Stall;
  logic              Branch_En;
  logic [ADDR_W-1:0] Branch_Addr;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Data;
  logic [DATA_W-1:0] Instr;
  logic              Instr_Valid;
  logic [ADDR_W-1:0] PC;
  logic              Halted;
  logic [1:0]        State_Dbg;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Stall(Stall),
    .Branch_En(Branch_En), .Branch_Addr(Branch_Addr), .Addr(Addr),
    .Data(Data), .Instr(Instr), .Instr_Valid(Instr_Valid), .PC(PC),
    .Halted(Halted), .State_Dbg(State_Dbg)
  );

  assign Data = mem[Addr];

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one rising edge, then settle
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    32'(PC),          32'd0);
    check({tag, "_addr"},  32'(Addr),        32'd0);
    check({tag, "_instr"}, 32'(Instr),       32'd0);
    check({tag, "_valid"}, 32'(Instr_Valid), 32'd0);
    check({tag, "_halt"},  32'(Halted),      32'd0);
    check({tag, "_state"}, 32'(State_Dbg),   32'd0);
  endtask

  // pulse reset between edges and confirm outputs clear before the next edge
  task automatic async_reset_pulse(input string tag);
    #2 Rst_n = 1'b0;
    #1 check_reset_values(tag);
    #1 Rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h8000 + 16'(i);
    mem[0] = 16'h6001;
    mem[1] = 16'h6301;
    mem[3] = 16'h0000;

    Rst_n = 1'b0; Enable = 1'b0; Stall = 1'b0; Branch_En = 1'b0; Branch_Addr = '0;
    #12;
    check_reset_values("rst");
    Rst_n = 1'b1;
    tick();
    check("idle_addr", 32'(Addr), 32'd0);
    check("idle_valid", 32'(Instr_Valid), 32'd0);

    // reset / run
    Enable = 1'b1;
    exp_q.push_back(16'h6001);
    exp_q.push_back(16'h6301);
    tick();
    check("run_addr0", 32'(Addr), 32'd0);
    check("run_v0", 32'(Instr_Valid), 32'd0);
    tick();
    check("run_instr0", 32'(Instr), 32'(exp_q.pop_front()));
    check("run_v1", 32'(Instr_Valid), 32'd1);
    check("run_addr1", 32'(Addr), 32'd1);
    tick();
    check("run_instr1", 32'(Instr), 32'(exp_q.pop_front()));
    check("run_v2", 32'(Instr_Valid), 32'd1);
    check("run_addr2", 32'(Addr), 32'd2);

    // stall at PC=5 with a valid instruction held
    Branch_En = 1'b1; Branch_Addr = 11'd4;
    tick();
    Branch_En = 1'b0;
    check("br4_pc", 32'(PC), 32'd4);
    check("br4_valid", 32'(Instr_Valid), 32'd0);
    check("br4_instr_held", 32'(Instr), 32'h6301);
    tick();
    check("f4_instr", 32'(Instr), 32'h8004);
    check("f4_pc", 32'(PC), 32'd5);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(PC), 32'd5);
      check("stall_instr", 32'(Instr), 32'h8004);
      check("stall_valid", 32'(Instr_Valid), 32'd1);
    end
    Stall = 1'b0;
    tick();
    check("resume_instr", 32'(Instr), 32'h8005);
    check("resume_pc", 32'(PC), 32'd6);

    // branch beats stall
    Branch_En = 1'b1; Stall = 1'b1; Branch_Addr = 11'd1000;
    tick();
    Branch_En = 1'b0; Stall = 1'b0;
    check("brst_pc", 32'(PC), 32'd1000);
    check("brst_valid", 32'(Instr_Valid), 32'd0);
    check("brst_instr_held", 32'(Instr), 32'h8005);
    tick();
    check("brst_instr", 32'(Instr), 32'h83E8);
    check("brst_v", 32'(Instr_Valid), 32'd1);
    check("brst_pc2", 32'(PC), 32'd1001);

    // Enable low beats branch; branch ignored in IDLE
    Enable = 1'b0; Branch_En = 1'b1; Branch_Addr = 11'd7;
    tick();
    check("dis_state", 32'(State_Dbg), 32'd0);
    check("dis_pc", 32'(PC), 32'd1001);
    check("dis_valid", 32'(Instr_Valid), 32'd0);
    tick();
    check("idle_br_pc", 32'(PC), 32'd1001);
    Branch_En = 1'b0; Enable = 1'b1;
    tick();
    check("reen_state", 32'(State_Dbg), 32'd1);
    check("reen_valid", 32'(Instr_Valid), 32'd0);

    // wrap
    Branch_En = 1'b1; Branch_Addr = 11'd2047;
    tick();
    Branch_En = 1'b0;
    check("wrap_pc", 32'(PC), 32'd2047);
    tick();
    check("wrap_instr", 32'(Instr), 32'h87FF);
    check("wrap_pc0", 32'(PC), 32'd0);
    tick();
    check("wrap_instr0", 32'(Instr), 32'h6001);
    check("wrap_pc1", 32'(PC), 32'd1);

    // async reset mid-stall
    Stall = 1'b1;
    tick();
    async_reset_pulse("rst_stall");
    Stall = 1'b0;

    // halt on opcode zero at Mem[3]
    tick();  // IDLE -> FETCH
    tick();  // Mem[0]
    tick();  // Mem[1]
    tick();  // Mem[2]
    check("pre_halt_pc", 32'(PC), 32'd3);
    tick();  // Mem[3] = 0000
    check("halt_instr", 32'(Instr), 32'h0000);
    check("halt_valid", 32'(Instr_Valid), 32'd1);
`ifdef INSTR_FETCH_HALT_DETECT_EN
    check("halt_flag", 32'(Halted), 32'd1);
    check("halt_pc", 32'(PC), 32'd3);
    Branch_En = 1'b1; Branch_Addr = 11'd9;
    tick();
    Branch_En = 1'b0;
    check("halt_hold_pc", 32'(PC), 32'd3);
    check("halt_hold_valid", 32'(Instr_Valid), 32'd0);
    check("halt_hold_flag", 32'(Halted), 32'd1);
    check("halt_hold_instr", 32'(Instr), 32'h0000);
    async_reset_pulse("rst_halt");
`else
    check("nohalt_flag", 32'(Halted), 32'd0);
    check("nohalt_pc", 32'(PC), 32'd4);
    tick();
    check("nohalt_instr", 32'(Instr), 32'h8004);
    check("nohalt_pc5", 32'(PC), 32'd5);
    async_reset_pulse("rst_run");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // hard bound on run time
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, program-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction width; opcode = Data[DATA_W-1:DATA_W-5].
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Enable  input  1  run request; low parks the fetcher.
REQ-007 SHALL have port Stall  input  1  downstream not ready; hold all state.
REQ-008 SHALL have port Branch_En  input  1  load PC from Branch_Addr this cycle.
REQ-009 SHALL have port Branch_Addr  input  ADDR_W  branch/jump target.
REQ-010 SHALL have port Addr  output  ADDR_W  program-memory address, combinationally equal to PC.
REQ-011 SHALL have port Data  input  DATA_W  program-memory read data, combinational from Addr.
REQ-012 SHALL have port Instr  output  DATA_W  registered fetched instruction.
REQ-013 SHALL have port Instr_Valid  output  1  Instr holds a new instruction this cycle.
REQ-014 SHALL have port PC  output  ADDR_W  current program counter.
REQ-015 SHALL have port Halted  output  1  fetcher in HALT state.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HALT.
REQ-017 SHALL, in IDLE: Instr_Valid=0, PC held; Enable=1 -> FETCH next cycle (first capture one cycle after entering FETCH).
REQ-018 SHALL, in FETCH with Enable=1, Stall=0, Branch_En=0: Instr<=Data, Instr_Valid<=1, PC<=PC+1; one instruction per cycle, latency one cycle from Addr to Instr.
REQ-019 SHALL wrap PC from 2**ADDR_W-1 to 0 with no flag or error.
REQ-020 SHALL, on Branch_En=1 in FETCH: PC<=Branch_Addr, Instr_Valid<=0, Instr held (flush); Branch_En overrides Stall when both high.
REQ-021 SHALL, on Stall=1 (Branch_En=0): hold PC, Instr, Instr_Valid unchanged.
REQ-022 SHALL, on Enable=0 in FETCH: go IDLE, Instr_Valid<=0, PC held; Enable takes priority over Branch_En and Stall.
REQ-023 SHALL ignore Branch_En in IDLE and HALT.
REQ-024 SHALL drive Halted=1 only in HALT; in HALT PC, Instr held, Instr_Valid=0 after the halt instruction's valid cycle.

Reset
REQ-025 SHALL, on Rst_n=0 at any time (including mid-stall or HALT): state=IDLE, PC=RESET_PC, Instr=0, Instr_Valid=0, Halted=0, asynchronously.
REQ-026 SHALL leave reset synchronously: first state change no earlier than first rising Clk with Rst_n=1.

Configuration
REQ-027 SHALL honour macro INSTR_FETCH_HALT_DETECT_EN.
REQ-028 SHALL, with INSTR_FETCH_HALT_DETECT_EN defined: a normal FETCH capture whose opcode is 5'b00000 asserts Instr_Valid for that instruction, leaves PC pointing at it (no increment), enters HALT; exit only via reset.
REQ-029 SHALL, without INSTR_FETCH_HALT_DETECT_EN: opcode 5'b00000 treated as ordinary, HALT unreachable, Halted tied 0.

Verification
REQ-030 SHALL verify reset/run: Rst_n low then high, Enable=1, Mem[0]=16'h6001, Mem[1]=16'h6301 -> Addr 0,0,1,2; Instr 16'h6001 then 16'h6301 on consecutive cycles with Instr_Valid=1.
REQ-031 SHALL verify stall: Stall=1 for 3 cycles at PC=5 -> PC stays 5, Instr/Instr_Valid frozen; resumes with Mem[5] next cycle.
REQ-032 SHALL verify branch vs stall: Branch_En=1, Stall=1, Branch_Addr=11'd1000 -> next PC=1000, Instr_Valid=0; following cycle Instr=Mem[1000].
REQ-033 SHALL verify wrap: branch to 11'd2047 -> fetch Mem[2047], then PC=0, Instr=Mem[0].
REQ-034 SHALL verify halt (macro defined): Mem[3]=16'h0000 -> Instr=16'h0000 valid once, Halted=1, PC=3 held; macro undefined -> PC=4, Halted=0.
REQ-035 SHALL verify async reset mid-HALT and mid-stall: Rst_n pulse between clock edges -> outputs reach reset values before next edge.
